// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list low-to-high, one access per set bit.
// Latency n+1 cycles after start with mem_ready high; each mem_ready-low cycle stalls in place.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] base_value,
  input  logic              mem_ready,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        xfer_reg,
  output logic              reg_write,
  output logic              pc_load,
  output logic              wb_en,
  output logic [3:0]        wb_reg,
  output logic [ADDR_W-1:0] wb_value,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_XFER   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_list;
  logic                r_l;
  logic                r_w;
  logic                r_base_loaded;
  logic [3:0]          r_rn;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_wb_value;

  logic                w_p;
  logic                w_u;
  logic [4:0]          w_n;
  logic [ADDR_W-1:0]   w_n4;
  logic [ADDR_W-1:0]   w_start_addr;
  logic [3:0]          w_low;
  logic [15:0]         w_list_after;
  logic                w_last;
  logic                w_accept;
  logic                w_unused;

  assign w_p      = instr[24];
  assign w_u      = instr[23];
  assign w_unused = ^{instr[31:25], instr[22]};
  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_n = w_n + 5'(instr[i]);
    end
  end

  assign w_n4 = {{(ADDR_W-7){1'b0}}, w_n, 2'b00};

  // Descending modes start low enough that addresses always ascend.
  always_comb begin
    case ({w_p, w_u})
      2'b01:   w_start_addr = base_value;
      2'b11:   w_start_addr = base_value + ADDR_W'(4);
      2'b00:   w_start_addr = base_value - w_n4 + ADDR_W'(4);
      default: w_start_addr = base_value - w_n4;
    endcase
  end

  always_comb begin
    w_low = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_list[i]) w_low = 4'(i);
    end
  end

  assign w_list_after = r_list & ~(16'h0001 << w_low);
  assign w_last       = (w_list_after == 16'h0000);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (w_n != 5'd0) ? S_XFER : S_FINISH;
      end
      S_XFER: begin
        if (mem_ready && w_last) w_next = S_FINISH;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_list        <= 16'h0000;
      r_l           <= 1'b0;
      r_w           <= 1'b0;
      r_base_loaded <= 1'b0;
      r_rn          <= 4'd0;
      r_addr        <= '0;
      r_wb_value    <= '0;
    end else if (w_accept) begin
      r_list        <= instr[15:0];
      r_l           <= instr[20];
      r_w           <= instr[21];
      r_base_loaded <= instr[20] && instr[instr[19:16]];
      r_rn          <= instr[19:16];
      r_addr        <= w_start_addr;
      r_wb_value    <= w_u ? (base_value + w_n4) : (base_value - w_n4);
    end else if (r_state == S_XFER && mem_ready) begin
      r_list <= w_list_after;
      r_addr <= r_addr + ADDR_W'(4);
    end
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    mem_read  = (r_state == S_XFER) && r_l;
    mem_write = (r_state == S_XFER) && !r_l;
    mem_addr  = r_addr;
    xfer_reg  = (r_state == S_XFER) ? w_low : 4'd0;
    reg_write = (r_state == S_XFER) && r_l && mem_ready;
    pc_load   = reg_write && (w_low == 4'd15);
    // A base register that was itself loaded keeps the loaded value.
    wb_en     = (r_state == S_FINISH) && r_w && !r_base_loaded;
    wb_reg    = r_rn;
    wb_value  = r_wb_value;
    done      = (r_state == S_FINISH);
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed table-driven bench for ldm_stm_sequencer plus stall, ignored-start and reset sequences.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instr;
  logic [31:0] base_value;
  logic        mem_ready;
  logic        busy, mem_read, mem_write, reg_write, pc_load, wb_en, done;
  logic [31:0] mem_addr, wb_value;
  logic [3:0]  xfer_reg, wb_reg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ldm_stm_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .base_value(base_value), .mem_ready(mem_ready), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .xfer_reg(xfer_reg), .reg_write(reg_write), .pc_load(pc_load),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_value(wb_value), .done(done)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] base;
    int          n;
    logic [31:0] first;
    logic [63:0] regs;     // nibble k = k-th register transferred
    logic        wb_en;
    logic [31:0] wb_val;
    logic [3:0]  wb_reg;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic       l;
    logic [3:0] r;
    l          = v.instr[20];
    start      = 1'b1;
    instr      = v.instr;
    base_value = v.base;
    @(negedge clk);
    chk("busy_in_start_cycle", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    instr = 32'h0;
    base_value = 32'hDEAD_BEEF;
    for (int k = 0; k < v.n; k++) begin
      r = v.regs[k*4 +: 4];
      @(negedge clk);
      chk("xfer_busy", 32'(busy), 32'd1);
      chk("xfer_mem_read", 32'(mem_read), 32'(l));
      chk("xfer_mem_write", 32'(mem_write), 32'(!l));
      chk("xfer_addr", mem_addr, v.first + 32'(4 * k));
      chk("xfer_reg", 32'(xfer_reg), 32'(r));
      chk("xfer_reg_write", 32'(reg_write), 32'(l));
      chk("xfer_pc_load", 32'(pc_load), 32'(l && r == 4'd15));
      chk("xfer_done", 32'(done), 32'd0);
      chk("xfer_wb_en", 32'(wb_en), 32'd0);
      step();
    end
    @(negedge clk);
    chk("fin_busy", 32'(busy), 32'd1);
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_access", 32'({mem_read, mem_write, reg_write}), 32'd0);
    chk("fin_wb_en", 32'(wb_en), 32'(v.wb_en));
    chk("fin_wb_reg", 32'(wb_reg), 32'(v.wb_reg));
    chk("fin_wb_value", wb_value, v.wb_val);
    step();
  endtask

  initial begin
    // LDMIA r0!, {r1,r2,r4}
    vecs[0] = '{32'hE8B0_0016, 32'h0000_0100, 3, 32'h0000_0100, 64'h421,   1'b1, 32'h0000_010C, 4'd0};
    // STMDB sp!, {r4-r7,lr}
    vecs[1] = '{32'hE92D_40F0, 32'h0000_1000, 5, 32'h0000_0FEC, 64'hE7654, 1'b1, 32'h0000_0FEC, 4'd13};
    // LDMIA r2!, {r1,r2}: loaded base suppresses writeback
    vecs[2] = '{32'hE8B2_0006, 32'h0000_0000, 2, 32'h0000_0000, 64'h21,    1'b0, 32'h0000_0008, 4'd2};
    // STMDA r0!, {}: no access
    vecs[3] = '{32'hE820_0000, 32'hFFFF_FFFC, 0, 32'h0000_0000, 64'h0,     1'b1, 32'hFFFF_FFFC, 4'd0};
    // LDMDB r5, {r0,r3,r8,r12}: start address wraps
    vecs[4] = '{32'hE915_1109, 32'h0000_0008, 4, 32'hFFFF_FFF8, 64'hC830,  1'b0, 32'hFFFF_FFF8, 4'd5};
    // LDMDA r6!, {r0,r1}
    vecs[5] = '{32'hE836_0003, 32'h0000_0200, 2, 32'h0000_01FC, 64'h10,    1'b1, 32'h0000_01F8, 4'd6};
    // STMIB r1!, {r1,pc}: stores never load PC, base in list still writes back
    vecs[6] = '{32'hE9A1_8002, 32'h0000_0040, 2, 32'h0000_0044, 64'hF1,    1'b1, 32'h0000_0048, 4'd1};

    reset = 1'b0; start = 1'b0; instr = 32'h0; base_value = 32'h0; mem_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_outputs", 32'({busy, mem_read, mem_write, reg_write, pc_load, wb_en, done}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_regs", 32'({xfer_reg, wb_reg}), 32'd0);
    chk("rst_wb_value", wb_value, 32'd0);
    step();
    reset = 1'b1;

    // Back-to-back: each vector starts in the first IDLE cycle after done.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    @(negedge clk);
    chk("idle_after_table", 32'({busy, done}), 32'd0);

    // LDMIB r3, {r15} with two stall cycles; a start during the stall is ignored.
    step();
    start = 1'b1; instr = 32'hE993_8000; base_value = 32'h20; mem_ready = 1'b0;
    step();
    start = 1'b0; instr = 32'h0;
    @(negedge clk);
    chk("stall0_addr", mem_addr, 32'h24);
    chk("stall0_reg_write", 32'({reg_write, pc_load}), 32'd0);
    chk("stall0_read", 32'(mem_read), 32'd1);
    step();
    start = 1'b1; instr = 32'hE8B0_FFFF; base_value = 32'h5000;
    @(negedge clk);
    chk("stall1_addr", mem_addr, 32'h24);
    chk("stall1_reg_write", 32'({reg_write, pc_load}), 32'd0);
    chk("stall1_xfer_reg", 32'(xfer_reg), 32'd15);
    step();
    start = 1'b0; instr = 32'h0; mem_ready = 1'b1;
    @(negedge clk);
    chk("ready_addr", mem_addr, 32'h24);
    chk("ready_reg_write", 32'(reg_write), 32'd1);
    chk("ready_pc_load", 32'(pc_load), 32'd1);
    step();
    @(negedge clk);
    chk("stall_fin_done", 32'(done), 32'd1);
    chk("stall_fin_wb_en", 32'(wb_en), 32'd0);
    chk("stall_fin_wb_reg", 32'(wb_reg), 32'd3);
    chk("stall_fin_wb_value", wb_value, 32'h24);
    step();
    @(negedge clk);
    chk("ignored_start_idle", 32'({busy, mem_read, done}), 32'd0);

    // Reset during the second XFER cycle of LDMIA r0, {r0-r3}.
    step();
    start = 1'b1; instr = 32'hE890_000F; base_value = 32'h300;
    step();
    start = 1'b0; instr = 32'h0;
    @(negedge clk);
    chk("rx_first_addr", mem_addr, 32'h300);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rx_second_reg", 32'(xfer_reg), 32'd1);
    chk("rx_second_addr", mem_addr, 32'h304);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rx_after_outputs", 32'({busy, mem_read, mem_write, reg_write, pc_load, wb_en, done}), 32'd0);
    chk("rx_after_addr", mem_addr, 32'd0);
    chk("rx_after_wb", wb_value, 32'd0);
    chk("rx_after_regs", 32'({xfer_reg, wb_reg}), 32'd0);
    step();
    @(negedge clk);
    chk("rx_stays_idle", 32'({busy, reg_write, wb_en, done}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-cycle sequencer for ARM block transfers (LDM/STM). Sits beside the single-cycle datapath and, once the decoder flags a block-transfer instruction, takes over the register-file and data-memory ports. It walks the 16-bit register list in ascending order and issues one memory access per set bit. It holds the program counter for the whole operation and finishes with an optional base-register writeback.

## Interface
Parameters:
- ADDR_W, 32, address/data width (only 32 supported)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low: reset==0 at a rising edge clears all state
- start  in  1  decoded LDM/STM valid this cycle; sampled only in IDLE
- instr  in  32  instruction word; uses P=[24], U=[23], W=[21], L=[20], Rn=[19:16], list=[15:0]
- base_value  in  32  current Rn contents, valid in the start cycle
- mem_ready  in  1  data memory accepts/completes the current access this cycle
- busy  out  1  sequencer active; stalls PC and fetch
- mem_read  out  1  load access request
- mem_write  out  1  store access request
- mem_addr  out  32  word address of current access
- xfer_reg  out  4  register being loaded/stored (drives read port 3 / write port 3 address)
- reg_write  out  1  write loaded data (read_data) to xfer_reg this cycle
- pc_load  out  1  with reg_write, xfer_reg==15: loaded value redirects PC
- wb_en  out  1  write wb_value to Rn this cycle
- wb_reg  out  4  = latched Rn
- wb_value  out  32  updated base
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, XFER, FINISH.
- IDLE:
  - When start==1, latch list, P, U, W, L, Rn and base_value.
  - Compute n = popcount(list), 0..16.
  - Compute the start address, all arithmetic mod 2^32:
    - IA (P0U1): base
    - IB (P1U1): base+4
    - DA (P0U0): base−4n+4
    - DB (P1U0): base−4n
  - Compute the writeback value: U ? base+4n : base−4n.
  - Go to XFER if n>0, else to FINISH.
- XFER:
  - xfer_reg = lowest remaining set bit of list.
  - mem_read=L, mem_write=~L, mem_addr = current address.
  - On mem_ready==1:
    - Clear that bit and add 4 to the address.
    - For loads, assert reg_write (and pc_load if xfer_reg==15) in the same cycle.
    - If no bits remain, go to FINISH.
  - If mem_ready==0, hold all outputs stable; there is no timeout.
- FINISH:
  - done=1.
  - wb_en = W && !(L && list[Rn]): a loaded base wins over writeback.
  - Next state is IDLE.
- Addresses always increment, so the lowest-numbered register is at the lowest address in all four modes.
- Stores with Rn in the list store the original base value; the datapath supplies it because writeback occurs only in FINISH.
- n==0: no memory access, done after one FINISH cycle, writeback of base±0 if W.

## Timing
- Reset values: state=IDLE; busy, mem_read, mem_write, reg_write, pc_load, wb_en and done all 0; mem_addr, xfer_reg, wb_reg and wb_value all 0.
- busy is combinational on state != IDLE, so it rises the cycle after the start cycle. The decoder holds start/instr stable in the start cycle only.
- start while busy is ignored.
- Latency is n + 1 cycles after the start cycle when mem_ready is always 1 (n XFER cycles plus FINISH). Each cycle of mem_ready==0 adds one cycle.
- reg_write and pc_load are asserted only in a cycle with mem_ready==1 and L==1.
- A new start is accepted in the first IDLE cycle after done, with no bubble required.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. No further access or writeback is issued.

## Test plan
- LDMIA r0!, {r1,r2,r4}, base=0x100, mem_ready=1:
  - Addresses 0x100, 0x104, 0x108 on xfer_reg 1, 2, 4 with reg_write each cycle.
  - FINISH: wb_en=1, wb_reg=0, wb_value=0x10C, done=1.
  - busy high for 4 cycles.
- STMDB sp!, {r4-r7,lr}, base=0x1000:
  - mem_write addresses 0xFEC..0xFFC ascending (r4, r5, r6, r7, r14).
  - wb_value=0xFEC.
- LDMIB r3, {r15}, base=0x20, mem_ready low for 2 cycles:
  - Address 0x24 held 3 cycles.
  - reg_write=pc_load=1 only in the ready cycle.
  - wb_en=0 (W=0).
- LDMIA r2!, {r1,r2}, base=0x0: wb_en=0 in FINISH because the loaded r2 wins. STMDA r0!, {} with base 0xFFFFFFFC: no access, done after 1 cycle, wb_value=0xFFFFFFFC.
- DB with base=0x8, n=4: start address wraps to 0xFFFFFFF8, addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- reset=0 during the second XFER cycle of a 4-register LDM: next cycle busy=0, no reg_write, no wb_en, no done. start pulsed while busy is ignored.
